// File: rtl/ledpanel_fb_writer.sv
// Frame-buffer writer: splits a raster RGB pixel stream into per-bit-plane
// writes into the back half of the double-buffered LED panel memory.
module ledpanel_fb_writer #(
  parameter int N_ROWS_MAX       = 64,
  parameter int N_COLS_MAX       = 256,
  parameter int BITDEPTH_MAX     = 8,
  parameter int MEM_DEPTH        = N_ROWS_MAX*N_COLS_MAX,
  parameter int W_MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)-1,
  parameter int W_MEM_DATA_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            ctrl_rst_n,
  input  logic                            ctrl_en,
  input  logic [31:0]                     ctrl_n_rows,
  input  logic [31:0]                     ctrl_n_cols,
  input  logic [31:0]                     ctrl_bitdepth,
  input  logic                            disp_buffer,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_sof,
  input  logic [3*BITDEPTH_MAX-1:0]       s_data,
  output logic                            mem_clk,
  output logic                            mem_we,
  output logic                            mem_buffer,
  output logic [W_MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [$clog2(BITDEPTH_MAX)-1:0] mem_bit,
  output logic [W_MEM_DATA_WIDTH-1:0]     mem_din,
  output logic [W_MEM_DATA_WIDTH-1:0]     mem_wmask,
  output logic                            frame_done,
  output logic                            frame_err
);

  localparam int N_LANES = 3;
  localparam int ROW_W   = $clog2(N_ROWS_MAX+1);
  localparam int COL_W   = $clog2(N_COLS_MAX+1);
  localparam int D_W     = $clog2(BITDEPTH_MAX+1);
  localparam int BIT_W   = $clog2(BITDEPTH_MAX);
  localparam int AW      = W_MEM_ADDR_WIDTH;
  localparam int PIX_W   = N_LANES*BITDEPTH_MAX;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t             state, nxt;
  logic [ROW_W-1:0]   rows_q, rows_in, row_q, half;
  logic [COL_W-1:0]   cols_q, cols_in, col_q;
  logic [D_W-1:0]     d_q, d_in, plane_q, nxt_plane, src_d;
  logic [AW-1:0]      addr_q, src_addr;
  logic               bot_q, src_bot;
  logic [PIX_W-1:0]   pix_q, src_pix;
  logic [BIT_W-1:0]   cbit;
  logic [N_LANES-1:0] lanes;
  logic               accept, start, take, last_plane, last_pix, advance;

  assign mem_clk = clk;

  // Frame geometry is sanitised at latch time so a bad config can't run the
  // counters past the memory.
  always_comb begin
    d_in = ctrl_bitdepth[D_W-1:0];
    if (ctrl_bitdepth == '0) d_in = D_W'(1);
    else if (ctrl_bitdepth > 32'(BITDEPTH_MAX)) d_in = D_W'(BITDEPTH_MAX);
    rows_in = {ctrl_n_rows[ROW_W-1:1], 1'b0};
    if (ctrl_n_rows > 32'(N_ROWS_MAX)) rows_in = ROW_W'(N_ROWS_MAX);
    else if (ctrl_n_rows < 32'd2) rows_in = ROW_W'(2);
    cols_in = ctrl_n_cols[COL_W-1:0];
    if (ctrl_n_cols > 32'(N_COLS_MAX)) cols_in = COL_W'(N_COLS_MAX);
    else if (ctrl_n_cols == '0) cols_in = COL_W'(1);
  end

  assign half       = rows_q >> 1;
  assign accept     = s_valid && s_ready && ctrl_en;
  assign start      = accept && s_sof && (state == IDLE || state == ACCEPT);
  assign take       = accept && (state == ACCEPT);
  assign last_plane = (state == WRITE) && (plane_q == d_q - D_W'(1));
  assign last_pix   = (row_q == rows_q - ROW_W'(1)) && (col_q == cols_q - COL_W'(1));
  assign advance    = ctrl_en && last_plane && !last_pix;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = WRITE;
      ACCEPT:  if (accept) nxt = WRITE;
      WRITE:   if (last_plane) nxt = last_pix ? DONE : ACCEPT;
      default: nxt = IDLE;
    endcase
    if (!ctrl_en) nxt = IDLE;
  end

  // Output registers are loaded from next-state values so the first plane
  // lands the cycle right after acceptance; on acceptance the beat itself
  // (and, for sof, the fresh origin/depth) is the source.
  always_comb begin
    src_pix   = pix_q;
    src_addr  = addr_q;
    src_bot   = bot_q;
    src_d     = d_q;
    nxt_plane = plane_q + D_W'(1);
    if (state != WRITE) begin
      src_pix   = s_data;
      nxt_plane = '0;
      if (s_sof) begin
        src_addr = '0;
        src_bot  = 1'b0;
        src_d    = d_in;
      end
    end
    cbit = BIT_W'(BITDEPTH_MAX - 32'(src_d) + 32'(nxt_plane));
  end

  for (genvar c = 0; c < N_LANES; c++) begin : g_lane
    logic [BITDEPTH_MAX-1:0] chan;
    assign chan     = src_pix[(N_LANES-c)*BITDEPTH_MAX-1 -: BITDEPTH_MAX];
    assign lanes[c] = chan[cbit];
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state   <= IDLE;
      plane_q <= '0;
    end else begin
      state   <= nxt;
      plane_q <= (nxt == WRITE) ? nxt_plane : '0;
    end
  end

  // Address is a running counter restarted at the half boundary, so it
  // tracks (row mod H)*cols + col without a multiplier.
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      rows_q <= '0;
      cols_q <= '0;
      d_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      bot_q  <= 1'b0;
      pix_q  <= '0;
    end else begin
      if (start) begin
        rows_q <= rows_in;
        cols_q <= cols_in;
        d_q    <= d_in;
        row_q  <= '0;
        col_q  <= '0;
        addr_q <= '0;
        bot_q  <= 1'b0;
      end else if (advance) begin
        addr_q <= addr_q + AW'(1);
        if (col_q == cols_q - COL_W'(1)) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
          if (row_q + ROW_W'(1) == half) begin
            addr_q <= '0;
            bot_q  <= 1'b1;
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (start || take) pix_q <= s_data;
    end
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      s_ready    <= 1'b0;
      mem_we     <= 1'b0;
      mem_buffer <= 1'b0;
      mem_addr   <= '0;
      mem_bit    <= '0;
      mem_din    <= '0;
      mem_wmask  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      s_ready    <= ctrl_en && (nxt == IDLE || nxt == ACCEPT);
      mem_we     <= (nxt == WRITE);
      frame_done <= (nxt == DONE);
      frame_err  <= start && (state == ACCEPT);
      if (start) mem_buffer <= ~disp_buffer;
      if (nxt == WRITE) begin
        mem_bit   <= nxt_plane[BIT_W-1:0];
        mem_addr  <= src_addr;
        mem_wmask <= src_bot ? 6'b111000 : 6'b000111;
        mem_din   <= src_bot ? {lanes, 3'b000} : {3'b000, lanes};
      end
    end
  end

endmodule

// File: doc/ledpanel_fb_writer.md
Name: ledpanel_fb_writer

Overview:
- Frame-buffer writer that feeds the double-buffered bit-plane BRAM read by the LED panel scan driver.
- Accepts a raster-order pixel stream (24-bit RGB, valid/ready, start-of-frame flag) and decomposes each pixel into per-bit-plane writes.
- Always writes into the buffer not currently displayed. Pulses frame_done when a full frame has been committed.

Parameters:
- N_ROWS_MAX, 64: max panel rows (top + bottom halves).
- N_COLS_MAX, 256: max chained columns.
- BITDEPTH_MAX, 8: bits per colour stored in memory; also the input width per colour.
- MEM_DEPTH, N_ROWS_MAX*N_COLS_MAX: derived, do not override.
- W_MEM_ADDR_WIDTH, $clog2(MEM_DEPTH)-1: derived, half-frame address width.
- W_MEM_DATA_WIDTH, 6: derived. Lanes are R0,G0,B0,R1,G1,B1 at bits 0..5.

Ports:
- clk  in  1  global clock.
- ctrl_rst_n  in  1  asynchronous, active-low reset.
- ctrl_en  in  1  block enable.
- ctrl_n_rows  in  32  active rows; even, 2..N_ROWS_MAX.
- ctrl_n_cols  in  32  active columns, 1..N_COLS_MAX.
- ctrl_bitdepth  in  32  planes written per pixel.
- disp_buffer  in  1  buffer index currently displayed by the scan driver.
- s_valid  in  1  pixel beat valid.
- s_ready  out  1  pixel beat accepted when s_valid&&s_ready.
- s_sof  in  1  beat is pixel (0,0) of a frame.
- s_data  in  3*BITDEPTH_MAX  pixel, {R,G,B}, R in MSBs.
- mem_clk  out  1  equals clk.
- mem_we  out  1  write strobe.
- mem_buffer  out  1  buffer being written.
- mem_addr  out  W_MEM_ADDR_WIDTH  half-frame pixel address.
- mem_bit  out  $clog2(BITDEPTH_MAX)  bit-plane index.
- mem_din  out  6  write data.
- mem_wmask  out  6  per-lane write enable.
- frame_done  out  1  one-cycle pulse after the last plane of the last pixel is written.
- frame_err  out  1  one-cycle pulse on a frame abort (see Behaviour).

Behaviour:
- Reset (async assert, sync release) values: state IDLE; s_ready=0; mem_we=0; mem_din=0; mem_wmask=0; mem_addr=0; mem_bit=0; mem_buffer=0; frame_done=0; frame_err=0; row/col counters 0.
- Config latch: ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth are sampled on each accepted sof beat and held for the frame.
  - ctrl_bitdepth of 0 is used as 1; values above BITDEPTH_MAX are clamped to BITDEPTH_MAX. The latched value is D.
  - mem_buffer is latched to ~disp_buffer at the same point. A scan-driver swap mid-frame does not change mem_buffer.
- FSM IDLE:
  - s_ready=ctrl_en.
  - Accepted beats with s_sof=0 are discarded.
  - An accepted sof beat is captured as pixel (row 0, col 0) and moves the FSM to WRITE.
- FSM ACCEPT:
  - s_ready=1.
  - An accepted beat with s_sof=0 is captured as the next raster pixel and moves the FSM to WRITE.
  - An accepted beat with s_sof=1 pulses frame_err, re-latches config and buffer, restarts at (0,0), then moves to WRITE. No frame_done is issued for the aborted frame.
- FSM WRITE:
  - s_ready=0.
  - Runs D consecutive cycles with mem_we=1 and mem_bit=k, for k=0..D-1.
  - Plane k carries colour bit index BITDEPTH_MAX-D+k (MSB-aligned; plane 0 is the LSB displayed).
  - After plane D-1: if the pixel was (ctrl_n_rows-1, ctrl_n_cols-1), go to DONE; otherwise advance col (wrapping to 0 and incrementing row at ctrl_n_cols-1) and go to ACCEPT.
- FSM DONE:
  - frame_done=1 for one cycle, then IDLE.
- Throughput: one pixel per D+1 cycles. The first mem_we occurs the cycle after acceptance.
- Lane mapping:
  - Rows 0..H-1, where H=ctrl_n_rows/2: mem_wmask=6'b000111, mem_din[2:0]={B,G,R} bits.
  - Rows H..2H-1: mem_wmask=6'b111000, mem_din[5:3]={B,G,R} bits.
  - Unmasked lanes are driven 0.
- Address: mem_addr=(row mod H)*ctrl_n_cols+col. It is implemented with a running counter that resets to 0 at row H (no multiplier); the result must match the formula exactly.
- ctrl_en deasserted in any state:
  - Next cycle: state IDLE, mem_we=0, s_ready=0.
  - The partial frame is dropped; no frame_done and no frame_err.
- Reset mid-WRITE: mem_we drops asynchronously and no further planes are written.
- mem_din, mem_addr, mem_bit and mem_wmask are registered and change only with mem_we.

Test Plan:
- Config rows=4, cols=2, bitdepth=2, disp_buffer=0; send 8 pixels with s_data=24'hC0_40_80 and sof on the first. Required:
  - Every write has mem_buffer=1.
  - Each pixel produces 2 writes with mem_bit 0,1.
  - Top rows give mem_din lanes R,G,B = plane0 (1,1,0), plane1 (1,0,1).
  - mem_addr sequence is 0,1,2,3 for the top half, then 0,1,2,3 for the bottom half with mask 6'b111000.
  - frame_done pulses once.
- bitdepth=0 and bitdepth=12: exactly 1 and 8 writes per pixel respectively. bitdepth=12 uses colour bits 0..7.
- Non-sof beats in IDLE are accepted and produce no mem_we. The next sof starts at mem_addr 0.
- sof injected at pixel 5 of an 8-pixel frame: one frame_err pulse, writes restart at addr 0, and no frame_done until 8 further pixels.
- disp_buffer toggles 1→0 mid-frame: mem_buffer stays 0 until the next sof, then becomes 1.
- ctrl_en dropped during a WRITE plane: mem_we=0 the next cycle and no frame_done. Also assert ctrl_rst_n low asynchronously mid-cycle: all outputs go to reset values immediately.
